// File: rtl/q15_divider_pkg.sv
// Shared Q15 fixed-point definitions: widths, saturation constants, divider FSM encoding
// and the operand classification that decides saturation/divide-by-zero up front.
package q15_divider_pkg;

  localparam int Q15_W = 16;
  localparam int MAG_W = Q15_W + 1;
  localparam int ITERS = 15;
  localparam int CNT_W = 4;

  localparam logic [Q15_W-1:0] Q15_MAX  = 16'h7FFF;
  localparam logic [Q15_W-1:0] Q15_MIN  = 16'h8000;
  localparam logic [Q15_W-1:0] Q15_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic div_zero;  // D == 0
    logic mag_ge;    // |N| >= |D|, result saturates
    logic mag_eq;    // |N| == |D|
    logic neg;       // sign(N) xor sign(D)
    logic num_neg;   // sign(N), picks the divide-by-zero rail
  } div_class_t;

  // 17 bits so that |-32768| is representable exactly
  function automatic logic [MAG_W-1:0] q15_mag(input logic [Q15_W-1:0] v);
    logic [MAG_W-1:0] ext;
    ext = {v[Q15_W-1], v};
    return v[Q15_W-1] ? (~ext + MAG_W'(1)) : ext;
  endfunction

  function automatic div_class_t q15_classify(input logic [Q15_W-1:0] n,
                                              input logic [Q15_W-1:0] d);
    div_class_t c;
    logic [MAG_W-1:0] n_mag;
    logic [MAG_W-1:0] d_mag;
    n_mag      = q15_mag(n);
    d_mag      = q15_mag(d);
    c.div_zero = (d == Q15_ZERO);
    c.mag_ge   = (n_mag >= d_mag);
    c.mag_eq   = (n_mag == d_mag);
    c.neg      = n[Q15_W-1] ^ d[Q15_W-1];
    c.num_neg  = n[Q15_W-1];
    return c;
  endfunction

endpackage

// File: rtl/q15_div_step.sv
// One restoring-division iteration: shift the partial remainder, compare against |D|,
// subtract when it fits and emit the corresponding quotient bit.
module q15_div_step
  import q15_divider_pkg::*;
(
  input  logic [MAG_W-1:0] rem,
  input  logic [MAG_W-1:0] dmag,
  output logic [MAG_W-1:0] rem_next,
  output logic             qbit
);

  logic [MAG_W-1:0] shifted;

  // rem < |D| <= 32768 on every iteration, so the shift never loses a set bit
  always_comb begin
    shifted  = rem << 1;
    qbit     = (shifted >= dmag);
    rem_next = qbit ? (shifted - dmag) : shifted;
  end

endmodule

// File: rtl/q15_divider.sv
// Signed Q15 divider, Q = trunc(N * 2^15 / D), fixed 16-cycle latency, saturating,
// one quotient bit per CALC cycle with the result formatted in the DONE cycle.
module q15_divider
  import q15_divider_pkg::*;
(
  input  logic             xClk,
  input  logic             xReset,
  input  logic             xStart,
  input  logic [Q15_W-1:0] xDividend,
  input  logic [Q15_W-1:0] xDivisor,
  output logic [Q15_W-1:0] xQuotient,
  output logic             xBusy,
  output logic             xDone,
  output logic             xOverflow,
  output logic             xDivZero
);

  div_state_t       state_reg;
  div_state_t       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [MAG_W-1:0] rem_reg;
  logic [MAG_W-1:0] dmag_reg;
  logic [ITERS-1:0] quo_reg;
  div_class_t       class_reg;

  logic [Q15_W-1:0] quotient_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             ovf_reg;
  logic             dz_reg;

  logic             accept;
  logic             step_en;
  logic             finish;

  div_class_t       class_next;
  logic [MAG_W-1:0] n_mag;
  logic [MAG_W-1:0] d_mag;
  logic [MAG_W-1:0] rem_load;
  logic [MAG_W-1:0] step_rem;
  logic             step_bit;

  logic [Q15_W-1:0] mag_q;
  logic [Q15_W-1:0] result_q;
  logic             result_ovf;
  logic             result_dz;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge xClk or posedge xReset) begin
    if (xReset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (xStart) state_next = ST_CALC;
      ST_CALC: if (cnt_reg == CNT_W'(ITERS - 1)) state_next = ST_DONE;
      ST_DONE: state_next = xStart ? ST_CALC : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: control outputs ----------------
  always_comb begin
    accept  = 1'b0;
    step_en = 1'b0;
    finish  = 1'b0;
    case (state_reg)
      ST_IDLE: accept = xStart;
      ST_CALC: step_en = 1'b1;
      ST_DONE: begin
        finish = 1'b1;
        accept = xStart;
      end
      default: ;
    endcase
  end

  // ---------------- operand capture ----------------
  always_comb begin
    n_mag      = q15_mag(xDividend);
    d_mag      = q15_mag(xDivisor);
    class_next = q15_classify(xDividend, xDivisor);
    // saturating cases bypass the loop; a zero remainder keeps it quiet
    rem_load   = (class_next.div_zero || class_next.mag_ge) ? '0 : n_mag;
  end

  q15_div_step u_step (
    .rem      (rem_reg),
    .dmag     (dmag_reg),
    .rem_next (step_rem),
    .qbit     (step_bit)
  );

  // ---------------- iteration datapath ----------------
  always_ff @(posedge xClk or posedge xReset) begin
    if (xReset) begin
      cnt_reg   <= '0;
      rem_reg   <= '0;
      dmag_reg  <= '0;
      quo_reg   <= '0;
      class_reg <= '0;
    end else if (accept) begin
      cnt_reg   <= '0;
      rem_reg   <= rem_load;
      dmag_reg  <= d_mag;
      quo_reg   <= '0;
      class_reg <= class_next;
    end else if (step_en) begin
      cnt_reg   <= cnt_reg + CNT_W'(1);
      rem_reg   <= step_rem;
      quo_reg   <= {quo_reg[ITERS-2:0], step_bit};
    end
  end

  // ---------------- result formatting ----------------
  always_comb begin
    mag_q      = {1'b0, quo_reg};
    result_q   = Q15_ZERO;
    result_ovf = 1'b0;
    result_dz  = 1'b0;
    if (class_reg.div_zero) begin
      result_dz = 1'b1;
      result_q  = class_reg.num_neg ? Q15_MIN : Q15_MAX;
    end else if (class_reg.mag_ge) begin
      // -1.0 is exactly representable, +1.0 is not
      if (class_reg.neg) begin
        result_q   = Q15_MIN;
        result_ovf = ~class_reg.mag_eq;
      end else begin
        result_q   = Q15_MAX;
        result_ovf = 1'b1;
      end
    end else begin
      result_q = class_reg.neg ? (~mag_q + Q15_W'(1)) : mag_q;
    end
  end

  // ---------------- output registers ----------------
  always_ff @(posedge xClk or posedge xReset) begin
    if (xReset) begin
      quotient_reg <= Q15_ZERO;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      dz_reg       <= 1'b0;
    end else begin
      busy_reg <= (state_reg == ST_CALC);
      done_reg <= finish;
      if (finish) begin
        quotient_reg <= result_q;
        ovf_reg      <= result_ovf;
        dz_reg       <= result_dz;
      end
    end
  end

  assign xQuotient = quotient_reg;
  assign xBusy     = busy_reg;
  assign xDone     = done_reg;
  assign xOverflow = ovf_reg;
  assign xDivZero  = dz_reg;

endmodule

// File: tb/tb_q15_divider.sv
// Scoreboard bench for q15_divider: driver pushes arithmetic-model results, a negedge
// monitor pops on xDone and also checks output hold, busy window and done timing.
module tb_q15_divider;

  logic        xClk = 1'b0;
  logic        xReset = 1'b1;
  logic        xStart = 1'b0;
  logic [15:0] xDividend = 16'h0000;
  logic [15:0] xDivisor = 16'h0000;
  logic [15:0] xQuotient;
  logic        xBusy;
  logic        xDone;
  logic        xOverflow;
  logic        xDivZero;

  typedef struct {
    logic [15:0] n;
    logic [15:0] d;
    logic [15:0] q;
    logic        ovf;
    logic        dz;
    int          done_edge;
  } exp_t;

  exp_t        sb[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          txn = 0;
  logic [15:0] last_q = 16'h0000;
  logic        last_ovf = 1'b0;
  logic        last_dz = 1'b0;

  q15_divider dut (
    .xClk      (xClk),
    .xReset    (xReset),
    .xStart    (xStart),
    .xDividend (xDividend),
    .xDivisor  (xDivisor),
    .xQuotient (xQuotient),
    .xBusy     (xBusy),
    .xDone     (xDone),
    .xOverflow (xOverflow),
    .xDivZero  (xDivZero)
  );

  always #5 xClk = ~xClk;
  always @(posedge xClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the real values
  task automatic model(input logic [15:0] n, input logic [15:0] d,
                       output logic [15:0] q, output logic ovf, output logic dz);
    int ni, di, an, ad, r;
    bit neg;
    ni = $signed(n);
    di = $signed(d);
    ovf = 1'b0;
    dz = 1'b0;
    if (di == 0) begin
      dz = 1'b1;
      r = (ni >= 0) ? 32767 : -32768;
    end else begin
      an = (ni < 0) ? -ni : ni;
      ad = (di < 0) ? -di : di;
      neg = (ni < 0) != (di < 0);
      if (an >= ad) begin
        r = neg ? -32768 : 32767;
        ovf = !(neg && an == ad);
      end else begin
        r = (an * 32768) / ad;
        if (neg) r = -r;
      end
    end
    q = r[15:0];
  endtask

  // Called at a negedge: the following posedge samples the request
  task automatic issue(input logic [15:0] n, input logic [15:0] d);
    exp_t e;
    e.n = n;
    e.d = d;
    model(n, d, e.q, e.ovf, e.dz);
    e.done_edge = cyc + 17;
    sb.push_back(e);
    xDividend = n;
    xDivisor = d;
    xStart = 1'b1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge xClk);
      t++;
    end
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic single(input logic [15:0] n, input logic [15:0] d);
    @(negedge xClk);
    issue(n, d);
    @(negedge xClk);
    xStart = 1'b0;
    xDividend = 16'($urandom);
    xDivisor = 16'($urandom);
    drain();
  endtask

  // Monitor: runs on the falling edge, away from the DUT's active edge
  always @(negedge xClk) begin
    exp_t e;
    logic exp_busy;
    if (xReset === 1'b0) begin
      if (xDone === 1'b1) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: xDone=1 at edge %0d, required 0", cyc);
        end else begin
          e = sb.pop_front();
          txn++;
          $display("txn %0d: N=%h D=%h -> Q=%h ovf=%b dz=%b (model %h %b %b) edge %0d/%0d",
                   txn, e.n, e.d, xQuotient, xOverflow, xDivZero, e.q, e.ovf, e.dz,
                   cyc, e.done_edge);
          check("quotient", 32'(xQuotient), 32'(e.q));
          check("overflow", 32'(xOverflow), 32'(e.ovf));
          check("divzero", 32'(xDivZero), 32'(e.dz));
          check("done_edge", cyc, e.done_edge);
          last_q = e.q;
          last_ovf = e.ovf;
          last_dz = e.dz;
        end
      end else begin
        check("hold", 32'({xQuotient, xOverflow, xDivZero}), 32'({last_q, last_ovf, last_dz}));
      end
      exp_busy = 1'b0;
      if (sb.size() != 0) begin
        if (cyc >= sb[0].done_edge - 15 && cyc <= sb[0].done_edge - 1) exp_busy = 1'b1;
      end
      check("busy", 32'(xBusy), 32'(exp_busy));
    end
  end

  initial begin
    logic [15:0] n, d;
    int k;

    // power-on reset
    repeat (3) @(negedge xClk);
    check("rst_quotient", 32'(xQuotient), 32'h0);
    check("rst_flags", 32'({xBusy, xDone, xOverflow, xDivZero}), 32'h0);
    #2 xReset = 1'b0;

    // directed corner cases
    single(16'h2000, 16'h4000);
    single(16'h0001, 16'h0003);
    single(16'hFFFF, 16'h0003);
    single(16'h4000, 16'h2000);
    single(16'h4000, 16'hC000);
    single(16'h1234, 16'h0000);
    single(16'h8000, 16'h0000);
    single(16'h0000, 16'h8000);
    single(16'h8000, 16'h8000);
    single(16'h8000, 16'h7FFF);

    // start held high across three operations; operands change while in CALC
    @(negedge xClk);
    for (int i = 0; i < 3; i++) begin
      n = 16'($urandom_range(0, 16'h3FFF));
      d = 16'($urandom_range(16'h4000, 16'h7FFF));
      if (i == 1) n = -n;
      issue(n, d);
      @(negedge xClk);
      xDividend = 16'($urandom);
      xDivisor = 16'($urandom);
      if (i == 2) xStart = 1'b0;
      else repeat (15) @(negedge xClk);
    end
    drain();

    // reset during CALC cycle 7 aborts the operation
    @(negedge xClk);
    issue(16'h1111, 16'h2222);
    @(negedge xClk);
    xStart = 1'b0;
    repeat (6) @(negedge xClk);
    #2 xReset = 1'b1;
    #1;
    check("midreset_quotient", 32'(xQuotient), 32'h0);
    check("midreset_flags", 32'({xBusy, xDone, xOverflow, xDivZero}), 32'h0);
    sb.delete();
    last_q = 16'h0000;
    last_ovf = 1'b0;
    last_dz = 1'b0;
    @(negedge xClk);
    #2 xReset = 1'b0;
    repeat (20) @(negedge xClk);
    single(16'h0001, 16'h0003);

    // randomized operand classes
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 5);
      n = 16'($urandom);
      d = 16'($urandom);
      case (k)
        1: d = 16'h0000;
        2: d = n;
        3: d = ~n + 16'h0001;
        4: n = 16'h0000;
        5: n = 16'($urandom_range(0, 255));
        default: ;
      endcase
      single(n, d);
    end

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
